// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared state encoding and counter widths for the SPI bus arbiter
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    XFER      = 2'd1,
    WAIT_NEXT = 2'd2,
    GAP       = 2'd3
  } state_t;

  // Sized for the parameter ranges GAP_CYCLES 1..15 and TIMEOUT 1..255.
  localparam int GAP_W = 4;
  localparam int TO_W  = 8;

endpackage

// File: rtl/spi_arb_pick.sv
// rtl/spi_arb_pick.sv - one-hot owner pick for two requesters
// SPI_ARB_RR_EN: simultaneous requests go to the requester not granted last.
module spi_arb_pick (
  input  logic       req_a,
  input  logic       req_b,
  input  logic       last_a,
  output logic [1:0] pick
);

`ifdef SPI_ARB_RR_EN
  always_comb begin
    pick = 2'b00;
    if (req_a && req_b) pick = last_a ? 2'b10 : 2'b01;
    else if (req_a)     pick = 2'b01;
    else if (req_b)     pick = 2'b10;
  end
`else
  logic unused_last_a;
  assign unused_last_a = last_a;

  always_comb begin
    pick = 2'b00;
    if (req_a)      pick = 2'b01;
    else if (req_b) pick = 2'b10;
  end
`endif

endmodule

// File: rtl/spi_arb.sv
// rtl/spi_arb.sv - two-requester SPI bus arbiter with inter-owner gap and idle timeout
// SPI_ARB_RR_EN selects round-robin instead of fixed A priority (see spi_arb_pick).
module spi_arb
  import spi_arb_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_A,
  input  logic       REQ_B,
  input  logic [7:0] TX_A,
  input  logic [7:0] TX_B,
  input  logic       LAST_A,
  input  logic       LAST_B,
  output logic       GNT_A,
  output logic       GNT_B,
  output logic       ACK_A,
  output logic       ACK_B,
  output logic [7:0] RX,
  output logic       SPI_START,
  output logic [7:0] SPI_TX,
  input  logic       SPI_DONE,
  input  logic [7:0] SPI_RX,
  output logic       SS,
  output logic       TOUT
);

  state_t             state;
  logic [GAP_W-1:0]   gap_cnt;
  logic [TO_W-1:0]    idle_cnt;
  logic               last_q;
  logic               last_gnt_a;
  logic [1:0]         pick;
  logic               own_req;
  logic [7:0]         own_tx;
  logic               own_last;

  spi_arb_pick u_pick (
    .req_a  (REQ_A),
    .req_b  (REQ_B),
    .last_a (last_gnt_a),
    .pick   (pick)
  );

  assign own_req  = GNT_A ? REQ_A  : REQ_B;
  assign own_tx   = GNT_A ? TX_A   : TX_B;
  assign own_last = GNT_A ? LAST_A : LAST_B;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      idle_cnt   <= '0;
      last_q     <= 1'b0;
      last_gnt_a <= 1'b0;
      GNT_A      <= 1'b0;
      GNT_B      <= 1'b0;
      ACK_A      <= 1'b0;
      ACK_B      <= 1'b0;
      RX         <= 8'h00;
      SPI_START  <= 1'b0;
      SPI_TX     <= 8'h00;
      SS         <= 1'b1;
      TOUT       <= 1'b0;
    end else begin
      ACK_A     <= 1'b0;
      ACK_B     <= 1'b0;
      SPI_START <= 1'b0;
      TOUT      <= 1'b0;
      case (state)
        IDLE: begin
          gap_cnt  <= '0;
          idle_cnt <= '0;
          if (|pick) begin
            GNT_A      <= pick[0];
            GNT_B      <= pick[1];
            last_gnt_a <= pick[0];
            SS         <= 1'b0;
            SPI_START  <= 1'b1;
            SPI_TX     <= pick[0] ? TX_A : TX_B;
            last_q     <= pick[0] ? LAST_A : LAST_B;
            state      <= XFER;
          end
        end
        XFER: begin
          if (SPI_DONE) begin
            RX       <= SPI_RX;
            ACK_A    <= GNT_A;
            ACK_B    <= GNT_B;
            idle_cnt <= '0;
            gap_cnt  <= '0;
            if (last_q) begin
              GNT_A <= 1'b0;
              GNT_B <= 1'b0;
              SS    <= 1'b1;
              state <= GAP;
            end else begin
              state <= WAIT_NEXT;
            end
          end
        end
        WAIT_NEXT: begin
          // The REQ seen during the ACK cycle still carries the byte just sent.
          if (own_req && !(ACK_A || ACK_B)) begin
            SPI_START <= 1'b1;
            SPI_TX    <= own_tx;
            last_q    <= own_last;
            idle_cnt  <= '0;
            state     <= XFER;
          end else if (idle_cnt == TO_W'(TIMEOUT - 1)) begin
            TOUT    <= 1'b1;
            GNT_A   <= 1'b0;
            GNT_B   <= 1'b0;
            SS      <= 1'b1;
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arb.sv
// tb/tb_spi_arb.sv - self-checking bench for spi_arb with byte-engine model and per-requester scoreboards
module tb_spi_arb;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       REQ_A, REQ_B, LAST_A, LAST_B;
  logic [7:0] TX_A, TX_B;
  logic       GNT_A, GNT_B, ACK_A, ACK_B;
  logic [7:0] RX;
  logic       SPI_START;
  logic [7:0] SPI_TX;
  logic       SPI_DONE;
  logic [7:0] SPI_RX;
  logic       SS, TOUT;

  spi_arb #(.GAP_CYCLES(2), .TIMEOUT(255)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .TX_A(TX_A), .TX_B(TX_B),
    .LAST_A(LAST_A), .LAST_B(LAST_B),
    .GNT_A(GNT_A), .GNT_B(GNT_B), .ACK_A(ACK_A), .ACK_B(ACK_B),
    .RX(RX), .SPI_START(SPI_START), .SPI_TX(SPI_TX),
    .SPI_DONE(SPI_DONE), .SPI_RX(SPI_RX), .SS(SS), .TOUT(TOUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    int         dly;
  } exp_t;

  typedef struct {
    bit         is_b;
    logic [7:0] tx;
    logic [7:0] rx;
    int         dly;
    bit         drop;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   tests = 0;
  int   fails = 0;
  int   acks  = 0;
  bit   stray_req = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Scoreboard: START checked against the owner's queue head, ACK pops it.
  always @(negedge CLK) begin : sb
    exp_t e;
    if (SPI_START) begin
      chk("start_gnt_onehot", int'(GNT_A) + int'(GNT_B), 1);
      if (GNT_A) begin
        if (q_a.size() == 0) chk("start_a_unexpected", 1, 0);
        else chk("spi_tx_a", int'(SPI_TX), int'(q_a[0].tx));
      end else if (GNT_B) begin
        if (q_b.size() == 0) chk("start_b_unexpected", 1, 0);
        else chk("spi_tx_b", int'(SPI_TX), int'(q_b[0].tx));
      end
    end
    if (ACK_A && ACK_B) chk("ack_both", 1, 0);
    if (ACK_A) begin
      acks++;
      if (q_a.size() == 0) chk("ack_a_unexpected", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("rx_a", int'(RX), int'(e.rx));
      end
    end
    if (ACK_B) begin
      acks++;
      if (q_b.size() == 0) chk("ack_b_unexpected", 1, 0);
      else begin
        e = q_b.pop_front();
        chk("rx_b", int'(RX), int'(e.rx));
      end
    end
  end

  // Byte engine model: DONE pulses dly cycles after START unless reset intervenes.
  initial begin : engine
    logic [7:0] rx;
    int         dly;
    bit         ab;
    SPI_DONE = 1'b0;
    SPI_RX   = 8'h00;
    forever begin
      @(negedge CLK);
      if (stray_req) begin
        SPI_RX   = 8'hEE;
        SPI_DONE = 1'b1;
        @(negedge CLK);
        SPI_DONE  = 1'b0;
        stray_req = 1'b0;
      end else if (SPI_START && !RESET) begin
        rx = 8'h00; dly = 4;
        if (GNT_A && q_a.size() != 0) begin rx = q_a[0].rx; dly = q_a[0].dly; end
        if (GNT_B && q_b.size() != 0) begin rx = q_b[0].rx; dly = q_b[0].dly; end
        ab = 1'b0;
        for (int i = 0; i < dly; i++) begin
          @(negedge CLK);
          if (RESET) ab = 1'b1;
        end
        if (!ab) begin
          SPI_RX   = rx;
          SPI_DONE = 1'b1;
          @(negedge CLK);
          SPI_DONE = 1'b0;
        end
      end
    end
  end

  task automatic drive(input bit is_b, input logic [7:0] tx, input bit last,
                       input logic [7:0] rx, input int dly);
    exp_t e;
    e.tx = tx; e.rx = rx; e.dly = dly;
    if (is_b) begin q_b.push_back(e); REQ_B = 1'b1; TX_B = tx; LAST_B = last; end
    else      begin q_a.push_back(e); REQ_A = 1'b1; TX_A = tx; LAST_A = last; end
  endtask

  task automatic wait_ack(input bit is_b, output int ss_hi, output int gnt_other);
    bit got;
    got = 1'b0; ss_hi = 0; gnt_other = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge CLK);
      if (is_b ? ACK_B : ACK_A) got = 1'b1;
      else begin
        if (SS) ss_hi++;
        if (is_b ? GNT_A : GNT_B) gnt_other++;
      end
    end
    chk(is_b ? "ack_b_seen" : "ack_a_seen", int'(got), 1);
    if (is_b) REQ_B = 1'b0; else REQ_A = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vt[4];
    int   s1, s2, s3, g1, g2, g3, n, a0;
    bit   exp_b;

    RESET = 1'b1;
    REQ_A = 0; REQ_B = 0; LAST_A = 0; LAST_B = 0; TX_A = 0; TX_B = 0;
    repeat (2) @(negedge CLK);
    chk("reset_ss", int'(SS), 1);
    chk("reset_flags", int'({GNT_A, GNT_B, ACK_A, ACK_B, TOUT, SPI_START}), 0);
    chk("reset_rx", int'(RX), 0);
    chk("reset_spi_tx", int'(SPI_TX), 0);
    RESET = 1'b0;
    @(negedge CLK);

    vt[0] = '{1'b0, 8'h9F, 8'h5A, 8, 1'b0};
    vt[1] = '{1'b1, 8'h3C, 8'hC3, 3, 1'b0};
    vt[2] = '{1'b0, 8'h00, 8'hFF, 1, 1'b1};
    vt[3] = '{1'b1, 8'hFF, 8'h66, 5, 1'b1};

    // Single-byte transactions, some with REQ dropped mid-transfer.
    for (int i = 0; i < 4; i++) begin
      drive(vt[i].is_b, vt[i].tx, 1'b1, vt[i].rx, vt[i].dly);
      if (vt[i].drop) begin
        @(negedge CLK);
        if (vt[i].is_b) REQ_B = 1'b0; else REQ_A = 1'b0;
      end
      wait_ack(vt[i].is_b, s1, g1);
      chk("ss_low_xfer", s1, 0);
      chk("gap_ss_first", int'(SS), 1);
      @(negedge CLK);
      chk("gap_ss_second", int'(SS), 1);
      chk("gap_gnt_low", int'(GNT_A | GNT_B), 0);
      repeat (3) @(negedge CLK);
    end

    // Stray SPI_DONE while idle.
    a0 = acks;
    stray_req = 1'b1;
    for (int i = 0; i < 10 && stray_req; i++) @(negedge CLK);
    repeat (4) @(negedge CLK);
    chk("stray_rx_unchanged", int'(RX), int'(vt[3].rx));
    chk("stray_no_ack", acks - a0, 0);

    // Three A bytes with B waiting: B must wait for the gap.
    drive(1'b0, 8'h01, 1'b0, 8'h11, 4);
    @(negedge CLK);
    drive(1'b1, 8'h44, 1'b1, 8'h55, 2);
    wait_ack(1'b0, s1, g1);
    drive(1'b0, 8'h02, 1'b0, 8'h22, 2);
    wait_ack(1'b0, s2, g2);
    drive(1'b0, 8'h03, 1'b1, 8'h33, 6);
    wait_ack(1'b0, s3, g3);
    chk("multi_ss_low", s1 + s2 + s3, 0);
    chk("multi_no_gnt_b", g1 + g2 + g3, 0);
    n = 0;
    while (!GNT_B && n < 50) begin @(negedge CLK); n++; end
    chk("gap_then_gnt_b", n, 3);
    wait_ack(1'b1, s1, g1);
    chk("b_no_gnt_a", g1, 0);
    repeat (4) @(negedge CLK);

    // Owner goes silent after a non-last byte.
    drive(1'b0, 8'hA5, 1'b0, 8'h5A, 2);
    wait_ack(1'b0, s1, g1);
    n = 0;
    while (!TOUT && n < 400) begin @(negedge CLK); n++; end
    chk("tout_latency", n, 255);
    chk("tout_ss_high", int'(SS), 1);
    chk("tout_gnt_low", int'(GNT_A), 0);
    @(negedge CLK);
    chk("tout_one_cycle", int'(TOUT), 0);
    repeat (4) @(negedge CLK);

    // Reset three cycles into a transfer.
    a0 = acks;
    drive(1'b0, 8'h77, 1'b1, 8'h88, 8);
    n = 0;
    while (!SPI_START && n < 20) begin @(negedge CLK); n++; end
    chk("rst_start_seen", int'(SPI_START), 1);
    repeat (3) @(negedge CLK);
    #1 RESET = 1'b1;
    #1;
    chk("rst_async_ss", int'(SS), 1);
    chk("rst_async_gnt", int'(GNT_A), 0);
    q_a.delete();
    REQ_A = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    repeat (15) @(negedge CLK);
    chk("rst_no_ack", acks - a0, 0);
    chk("rst_idle_ss", int'(SS), 1);
    chk("rst_idle_start", int'(SPI_START), 0);

    // Two rounds of simultaneous requests straight after reset.
    for (int k = 0; k < 2; k++) begin
`ifdef SPI_ARB_RR_EN
      exp_b = (k == 1);
`else
      exp_b = 1'b0;
`endif
      drive(exp_b, exp_b ? 8'h2B : 8'h1A, 1'b1, exp_b ? 8'hB2 : 8'hA1, 3);
      if (exp_b) begin REQ_A = 1'b1; TX_A = 8'h1A; LAST_A = 1'b1; end
      else       begin REQ_B = 1'b1; TX_B = 8'h2B; LAST_B = 1'b1; end
      @(negedge CLK);
      chk("both_pick_b", int'(GNT_B), int'(exp_b));
      chk("both_pick_a", int'(GNT_A), int'(!exp_b));
      wait_ack(exp_b, s1, g1);
      REQ_A = 1'b0; REQ_B = 1'b0;
      repeat (5) @(negedge CLK);
    end

    chk("sb_a_empty", q_a.size(), 0);
    chk("sb_b_empty", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
